// File: rtl/uart_rx_param_if.sv
// Receive-side word handshake and error pulses between uart_rx_param and its consumer.
// The receiver drives the word, valid and error pulses; the consumer drives ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_RX_Ready;
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Byte;
    logic                 o_Frame_Err;
    logic                 o_Parity_Err;
    logic                 o_Overrun;

    modport master (
        input  i_RX_Ready,
        output o_RX_DV,
        output o_RX_Byte,
        output o_Frame_Err,
        output o_Parity_Err,
        output o_Overrun
    );

    modport slave (
        output i_RX_Ready,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_Frame_Err,
        input  o_Parity_Err,
        input  o_Overrun
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (start, DATA_BITS data LSB first, optional parity, stop) with valid/ready output.
// Define UART_RX_PARITY_EN to add the parity bit and its check; otherwise o_Parity_Err stays 0.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic           i_Clock,
    input  logic           i_Rst_L,
    input  logic           i_RX_Serial,
    uart_rx_param_if.master rx_if
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
        , ST_PARITY = 3'd5
`endif
    } state_t;

    logic                 rx_meta_r, rx_sync_r, rx_s;
    state_t               state_r, state_nx_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
    logic [IDX_W-1:0]     idx_r, idx_nx_s;
    logic [DATA_BITS-1:0] shift_r, shift_nx_s;
    logic                 par_r, par_nx_s;
    logic                 done_r, done_s, ferr_s, par_bad_s;
    logic                 dv_r, ferr_r, perr_r, ovr_r;
    logic [DATA_BITS-1:0] byte_r;

    assign rx_s = rx_sync_r;

`ifdef UART_RX_PARITY_EN
    assign par_bad_s = par_r ^ (^shift_r) ^ (PARITY_ODD != 0);
`else
    // No parity bit on the line: the error can never fire, whatever PARITY_ODD says.
    assign par_bad_s = 1'b0 & (PARITY_ODD != 0);
`endif

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_RX_Serial;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM state, bit timer, bit index and data/parity capture registers.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            par_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            idx_r   <= idx_nx_s;
            shift_r <= shift_nx_s;
            par_r   <= par_nx_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic: every bit is sampled once, at its mid-point.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        idx_nx_s   = idx_r;
        shift_nx_s = shift_r;
        par_nx_s   = par_r;
        done_s     = 1'b0;
        ferr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = '0;
                idx_nx_s = '0;
                if (!rx_s) state_nx_s = ST_START;
                else       state_nx_s = ST_IDLE;
            end
            ST_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_nx_s = '0;
                    if (!rx_s) state_nx_s = ST_DATA;
                    else       state_nx_s = ST_IDLE;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nx_s           = '0;
                    shift_nx_s[idx_r]  = rx_s;
                    if (idx_r == IDX_LAST) begin
                        idx_nx_s = '0;
`ifdef UART_RX_PARITY_EN
                        state_nx_s = ST_PARITY;
`else
                        state_nx_s = ST_STOP;
`endif
                    end else begin
                        idx_nx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nx_s   = '0;
                    par_nx_s   = rx_s;
                    state_nx_s = ST_STOP;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nx_s = '0;
                    if (rx_s) begin
                        done_s     = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        ferr_s     = 1'b1;
                        state_nx_s = ST_BREAK;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                cnt_nx_s = '0;
                if (rx_s) state_nx_s = ST_IDLE;
                else      state_nx_s = ST_BREAK;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
                idx_nx_s   = '0;
            end
        endcase
    end

    // Delivery and handshake: a finished word loads unless an unaccepted word is still held.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            dv_r   <= 1'b0;
            byte_r <= '0;
            ferr_r <= 1'b0;
            perr_r <= 1'b0;
            ovr_r  <= 1'b0;
        end else begin
            ferr_r <= ferr_s;
            perr_r <= 1'b0;
            ovr_r  <= 1'b0;
            if (done_r) begin
                perr_r <= par_bad_s;
                if (!dv_r || rx_if.i_RX_Ready) begin
                    byte_r <= shift_r;
                    dv_r   <= 1'b1;
                end else begin
                    ovr_r <= 1'b1;
                end
            end else if (dv_r && rx_if.i_RX_Ready) begin
                dv_r <= 1'b0;
            end else begin
                dv_r <= dv_r;
            end
        end
    end

    assign rx_if.o_RX_DV      = dv_r;
    assign rx_if.o_RX_Byte    = byte_r;
    assign rx_if.o_Frame_Err  = ferr_r;
    assign rx_if.o_Parity_Err = perr_r;
    assign rx_if.o_Overrun    = ovr_r;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at 8 clocks/bit, 8 data bits, even parity when UART_RX_PARITY_EN is set.
module tb_uart_rx_param;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;

    int checks = 0;
    int errs = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] words[$];

    uart_rx_param_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_ODD(0)) dut (
        .i_Clock    (clk),
        .i_Rst_L    (rst_n),
        .i_RX_Serial(rx),
        .rx_if      (rx_if)
    );

    always #5 clk = ~clk;

    // Passive monitor: accepted words and error pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_if.o_RX_DV && rx_if.i_RX_Ready) words.push_back(rx_if.o_RX_Byte);
        if (rx_if.o_Frame_Err)  ferr_cnt++;
        if (rx_if.o_Parity_Err) perr_cnt++;
        if (rx_if.o_Overrun)    ovr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    int nw, nf, np, no;

    initial begin
        rx_if.i_RX_Ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_dv",   32'(rx_if.o_RX_DV), 32'h0);
        check_eq("rst_byte", 32'(rx_if.o_RX_Byte), 32'h0);
        check_eq("rst_ferr", 32'(rx_if.o_Frame_Err), 32'h0);
        check_eq("rst_perr", 32'(rx_if.o_Parity_Err), 32'h0);
        check_eq("rst_ovr",  32'(rx_if.o_Overrun), 32'h0);
        rst_n = 1'b1;
        idle_bits(2);

        // Back-to-back frames
        nw = words.size(); nf = ferr_cnt; np = perr_cnt; no = ovr_cnt;
        send_frame(8'hA5, ^8'hA5, 1'b1);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        idle_bits(3);
        check_eq("b2b_count", 32'(words.size() - nw), 32'd2);
        check_eq("b2b_w0", 32'(words[nw]), 32'hA5);
        check_eq("b2b_w1", 32'(words[nw + 1]), 32'h3C);
        check_eq("b2b_errs", 32'((ferr_cnt - nf) + (ovr_cnt - no)), 32'd0);
        check_eq("b2b_perr", 32'(perr_cnt - np), 32'd0);

        // Start-bit glitch, then a real frame 6 clocks later
        nw = words.size(); nf = ferr_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        send_frame(8'h96, ^8'h96, 1'b1);
        idle_bits(3);
        check_eq("glitch_count", 32'(words.size() - nw), 32'd1);
        check_eq("glitch_word", 32'(words[nw]), 32'h96);
        check_eq("glitch_ferr", 32'(ferr_cnt - nf), 32'd0);

        // Framing error with a 3-bit line break, then recovery
        nw = words.size(); nf = ferr_cnt;
        send_frame(8'h55, ^8'h55, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        idle_bits(2);
        check_eq("ferr_pulses", 32'(ferr_cnt - nf), 32'd1);
        check_eq("ferr_nodv", 32'(words.size() - nw), 32'd0);
        send_frame(8'h81, ^8'h81, 1'b1);
        idle_bits(3);
        check_eq("ferr_next", 32'(words[nw]), 32'h81);
        check_eq("ferr_once", 32'(ferr_cnt - nf), 32'd1);

        // Overrun while the consumer stalls
        nw = words.size(); no = ovr_cnt;
        rx_if.i_RX_Ready = 1'b0;
        send_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
        idle_bits(2);
        check_eq("ovr_dv", 32'(rx_if.o_RX_DV), 32'h1);
        check_eq("ovr_byte", 32'(rx_if.o_RX_Byte), 32'h11);
        check_eq("ovr_pulses", 32'(ovr_cnt - no), 32'd1);
        @(posedge clk);
        #1 rx_if.i_RX_Ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("ovr_dvclr", 32'(rx_if.o_RX_DV), 32'h0);
        check_eq("ovr_taken", 32'(words.size() - nw), 32'd1);
        check_eq("ovr_word", 32'(words[nw]), 32'h11);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        nw = words.size(); np = perr_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        idle_bits(2);
        check_eq("par_bad_err", 32'(perr_cnt - np), 32'd1);
        check_eq("par_bad_word", 32'(words[nw]), 32'h07);
        np = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(2);
        check_eq("par_ok_err", 32'(perr_cnt - np), 32'd0);
        check_eq("par_ok_word", 32'(words[nw + 1]), 32'h07);
`endif

        // Reset during data bit 4 while a word is held
        rx_if.i_RX_Ready = 1'b0;
        send_frame(8'h5A, ^8'h5A, 1'b1);
        idle_bits(2);
        check_eq("mrst_held", 32'(rx_if.o_RX_DV), 32'h1);
        nw = words.size(); nf = ferr_cnt; no = ovr_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_dv", 32'(rx_if.o_RX_DV), 32'h0);
        check_eq("mrst_byte", 32'(rx_if.o_RX_Byte), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rx = 1'b1;
        rx_if.i_RX_Ready = 1'b1;
        idle_bits(3);
        send_frame(8'hF0, ^8'hF0, 1'b1);
        idle_bits(3);
        check_eq("mrst_count", 32'(words.size() - nw), 32'd1);
        check_eq("mrst_word", 32'(words[nw]), 32'hF0);
        check_eq("mrst_nopulse", 32'((ferr_cnt - nf) + (ovr_cnt - no)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
